avmm_bridge_arbiter: RTL

- Two-requester to one-bridge Avalon-MM arbiter.
- Shares one PCP bridge port (e.g. slow_bridge: 32-bit data, 19-bit address, burstcount 1) between requester 0 (CPU-side master) and requester 1 (benchmark/DMA-side master).
- Sits in the clk100 domain between the requesters and the bridge master port.
- Tracks outstanding pipelined reads so that readdata returns to the originating requester.

---
 rtl/avmm_arb_pkg.sv | 14 +
 rtl/avmm_arb_tag_fifo.sv | 67 ++++++
 rtl/avmm_bridge_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/avmm_arb_pkg.sv
// Shared types for the two-requester Avalon-MM bridge arbiter.
// Requester IDs are one bit wide because there are exactly two requesters.
package avmm_arb_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

    typedef logic arb_id_t;

    localparam int ARB_N_REQ = 2;

endpackage

// File: rtl/avmm_arb_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding bridge read.
// Latency: push visible at head one cycle later; head and pop are combinational.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module avmm_arb_tag_fifo
    import avmm_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  arb_id_t          push_id_i,
    input  logic             pop_i,
    output arb_id_t          head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    arb_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths stay within the storage.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/avmm_bridge_arbiter.sv
// Two-requester to one-bridge Avalon-MM arbiter; ARB_FIXED_PRIO_EN selects fixed priority (requester 0).
// Latency: request at t -> bridge command at t+1; one transfer per grant (1-cycle bubble).
// Backpressure: s_waitrequest or a full read-tag FIFO stalls the granted requester; the other always waits.
module avmm_bridge_arbiter
    import avmm_arb_pkg::*;
#(
    parameter  int ADDR_W      = 19,
    parameter  int DATA_W      = 32,
    parameter  int MAX_PENDING = 4,
    localparam int BE_W        = DATA_W / 8,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk100_clk,
    input  logic              rst_clk100_reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_debugaccess,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_debugaccess,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    output logic              s_debugaccess,
    output logic              s_burstcount,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,

    output logic [CNT_W-1:0]  pending_cnt,
    output logic              err_spurious
);

    arb_state_t state_q;
    arb_id_t    grant_q;
    arb_id_t    last_grant_q;
    logic       err_q;

    arb_id_t    winner;
    logic       req0, req1;
    logic       granted;
    logic       g_read, g_write;
    logic       read_block;
    logic       stall;
    logic       accept;
    logic       tag_push, tag_pop;
    arb_id_t    tag_head;
    logic       tag_full, tag_empty;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        winner = arb_id_t'(1'b0);
        if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
            winner = arb_id_t'(1'b0);
`else
            winner = ~last_grant_q;
`endif
        end else if (req1) begin
            winner = arb_id_t'(1'b1);
        end
    end

    assign granted = (state_q == ARB_GRANTED);
    assign g_read  = grant_q ? m1_read  : m0_read;
    assign g_write = grant_q ? m1_write : m0_write;

    assign s_address     = grant_q ? m1_address     : m0_address;
    assign s_writedata   = grant_q ? m1_writedata   : m0_writedata;
    assign s_byteenable  = grant_q ? m1_byteenable  : m0_byteenable;
    assign s_debugaccess = grant_q ? m1_debugaccess : m0_debugaccess;
    assign s_burstcount  = 1'b1;

    // Registered full flag keeps s_readdatavalid out of the s_read path.
    assign read_block = granted & g_read & tag_full;
    assign s_read     = granted & g_read & ~tag_full;
    assign s_write    = granted & g_write;
    assign stall      = s_waitrequest | read_block;
    assign accept     = (s_read | s_write) & ~s_waitrequest;

    assign m0_waitrequest = (granted && (grant_q == 1'b0)) ? stall : 1'b1;
    assign m1_waitrequest = (granted && (grant_q == 1'b1)) ? stall : 1'b1;

    assign tag_push = accept & s_read;
    assign tag_pop  = s_readdatavalid;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid & ~tag_empty & (tag_head == 1'b0);
    assign m1_readdatavalid = s_readdatavalid & ~tag_empty & (tag_head == 1'b1);
    assign err_spurious     = err_q;

    avmm_arb_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk       (clk100_clk),
        .rst_n     (rst_clk100_reset_n),
        .push_i    (tag_push),
        .push_id_i (grant_q),
        .pop_i     (tag_pop),
        .head_o    (tag_head),
        .full_o    (tag_full),
        .empty_o   (tag_empty),
        .count_o   (pending_cnt)
    );

    always_ff @(posedge clk100_clk or negedge rst_clk100_reset_n) begin
        if (!rst_clk100_reset_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (req0 || req1) begin
                        grant_q <= winner;
                        state_q <= ARB_GRANTED;
                    end
                end
                ARB_GRANTED: begin
                    if (accept) begin
                        last_grant_q <= grant_q;
                        state_q      <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk100_clk or negedge rst_clk100_reset_n) begin
        if (!rst_clk100_reset_n) begin
            err_q <= 1'b0;
        end else if (s_readdatavalid && tag_empty) begin
            err_q <= 1'b1;
        end
    end

endmodule
